// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : detector_jogada
//  Description : Input conditioner for the game control unit. Synchronizes the
//                four raw player buttons, debounces press and release, and
//                emits one single-cycle 'jogada' pulse per accepted press.
//                Presses confirmed while 'habilita' is low are swallowed.
//  Ports       : clock        - system clock, rising edge
//                reset_n      - asynchronous active-low reset
//                botoes[3:0]  - raw asynchronous buttons, active-high
//                habilita     - control unit is waiting for a play
//                jogada       - one-cycle pulse marking an accepted play
//                jogada_valor - pattern of the last accepted play (held)
//                multiplas    - pulse with 'jogada' when >1 button is set
//                db_estado    - current FSM state code (7 = illegal)
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 1000   // must be >= 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic       jogada,
    output logic [3:0] jogada_valor,
    output logic       multiplas,
    output logic [2:0] db_estado
);

    localparam int              CW       = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0]   CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0]   CONT_UM  = CW'(1);

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA_PRESS = 3'd1,
        EMITE        = 3'd2,
        ESPERA_SOLTA = 3'd3,
        FILTRA_SOLTA = 3'd4
    } estado_t;

    estado_t        estado;
    estado_t        prox_estado;
    logic [3:0]     sinc_a;
    logic [3:0]     sinc;
    logic [3:0]     amostra;
    logic [3:0]     amostra_prox;
    logic [CW-1:0]  cont;
    logic [CW-1:0]  cont_prox;
    logic [3:0]     valor_reg;
    logic           aceita;

    // Two-flop synchronizer per button bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinc_a <= 4'd0;
            sinc   <= 4'd0;
        end else begin
            sinc_a <= botoes;
            sinc   <= sinc_a;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= OCIOSO;
            amostra   <= 4'd0;
            cont      <= '0;
            valor_reg <= 4'd0;
        end else begin
            estado  <= prox_estado;
            amostra <= amostra_prox;
            cont    <= cont_prox;
            if (aceita) begin
                valor_reg <= amostra;
            end
        end
    end

    always_comb begin
        prox_estado  = estado;
        amostra_prox = amostra;
        cont_prox    = cont;
        case (estado)
            OCIOSO: begin
                if (sinc != 4'd0) begin
                    amostra_prox = sinc;
                    cont_prox    = '0;
                    prox_estado  = FILTRA_PRESS;
                end
            end
            FILTRA_PRESS: begin
                if (sinc == 4'd0) begin
                    prox_estado = OCIOSO;
                end else if (sinc != amostra) begin
                    // A different pattern restarts the filter around it
                    amostra_prox = sinc;
                    cont_prox    = '0;
                end else if (cont == CONT_MAX) begin
                    prox_estado = EMITE;
                end else begin
                    cont_prox = cont + CONT_UM;
                end
            end
            EMITE: begin
                prox_estado = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                // Pattern changes while held are deliberately ignored
                if (sinc == 4'd0) begin
                    cont_prox   = '0;
                    prox_estado = FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (sinc != 4'd0) begin
                    prox_estado = ESPERA_SOLTA;
                end else if (cont == CONT_MAX) begin
                    prox_estado = OCIOSO;
                end else begin
                    cont_prox = cont + CONT_UM;
                end
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

    // Outputs are decoded from the state register; habilita only matters in
    // the emite cycle, so a press confirmed while disabled is lost for good.
    assign aceita       = (estado == EMITE) && habilita;
    assign jogada       = aceita;
    assign multiplas    = aceita && ((amostra & (amostra - 4'd1)) != 4'd0);
    // Bypass makes the new pattern visible in the same cycle as the pulse
    assign jogada_valor = aceita ? amostra : valor_reg;

    always_comb begin
        db_estado = 3'd7;
        case (estado)
            OCIOSO, FILTRA_PRESS, EMITE, ESPERA_SOLTA, FILTRA_SOLTA:
                db_estado = estado;
            default:
                db_estado = 3'd7;
        endcase
    end

endmodule
`default_nettype wire
